// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage: loads/stores over a req/ack data port, passthrough otherwise
// One op in flight: IDLE accepts, REQ waits for dmem_ack (or timeout), RESP holds the write-back record.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [5:0]  alucode_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  rd_addr_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [4:0]  out_rd_o,
   output logic        out_reg_we_o,
   output logic        out_err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam logic [5:0] ALU_LB  = 6'd9;
   localparam logic [5:0] ALU_LH  = 6'd10;
   localparam logic [5:0] ALU_LW  = 6'd11;
   localparam logic [5:0] ALU_LBU = 6'd12;
   localparam logic [5:0] ALU_LHU = 6'd13;
   localparam logic [5:0] ALU_SB  = 6'd14;
   localparam logic [5:0] ALU_SH  = 6'd15;
   localparam logic [5:0] ALU_SW  = 6'd16;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t      state_q;
   logic [5:0]  op_q;
   logic [1:0]  off_q;
   logic [4:0]  rd_q;
   logic [7:0]  cnt_q;
   logic        req_q, we_q, out_valid_q, out_err_q, out_reg_we_q;
   logic [31:0] addr_q, wdata_q, out_data_q;
   logic [3:0]  be_q;

   logic        is_ld, is_st, misal;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, load_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode of the incoming op, used only on the accept cycle.
   always_comb begin
      is_ld   = 1'b0;
      is_st   = 1'b0;
      misal   = 1'b0;
      be_d    = 4'b1111;
      wdata_d = store_data_i;
      unique case (alucode_i)
         ALU_LB, ALU_LBU: is_ld = 1'b1;
         ALU_LH, ALU_LHU: begin is_ld = 1'b1; misal = alu_result_i[0]; end
         ALU_LW:          begin is_ld = 1'b1; misal = |alu_result_i[1:0]; end
         ALU_SB: begin
            is_st   = 1'b1;
            be_d    = 4'b0001 << alu_result_i[1:0];
            wdata_d = {4{store_data_i[7:0]}};
         end
         ALU_SH: begin
            is_st   = 1'b1;
            misal   = alu_result_i[0];
            be_d    = 4'b0011 << alu_result_i[1:0];
            wdata_d = {2{store_data_i[15:0]}};
         end
         ALU_SW: begin is_st = 1'b1; misal = |alu_result_i[1:0]; end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel  = dmem_rdata_i[{off_q, 3'b000} +: 8];
      half_sel  = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
      load_data = dmem_rdata_i;
      unique case (op_q)
         ALU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         ALU_LBU: load_data = {24'd0, byte_sel};
         ALU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
         ALU_LHU: load_data = {16'd0, half_sel};
         default: load_data = dmem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         off_q        <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         out_reg_we_q <= 1'b0;
         out_data_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (in_valid_i) begin
               op_q  <= alucode_i;
               off_q <= alu_result_i[1:0];
               rd_q  <= rd_addr_i;
               cnt_q <= '0;
               if (!is_ld && !is_st) begin
                  out_data_q   <= alu_result_i;
                  out_err_q    <= 1'b0;
                  out_reg_we_q <= (rd_addr_i != 5'd0);
                  out_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end else if (misal) begin
                  out_data_q   <= '0;
                  out_err_q    <= 1'b1;
                  out_reg_we_q <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  addr_q  <= {alu_result_i[31:2], 2'b00};
                  be_q    <= be_d;
                  we_q    <= is_st;
                  wdata_q <= wdata_d;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (dmem_ack_i) begin
                  req_q        <= 1'b0;
                  out_data_q   <= we_q ? 32'd0 : load_data;
                  out_err_q    <= 1'b0;
                  out_reg_we_q <= !we_q && (rd_q != 5'd0);
                  out_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                  // Timeout: give up on the port and complete with an error record.
                  req_q        <= 1'b0;
                  out_data_q   <= '0;
                  out_err_q    <= 1'b1;
                  out_reg_we_q <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: if (out_ready_i) begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o   = (state_q == S_IDLE);
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_rd_o     = rd_q;
   assign out_reg_we_o = out_reg_we_q;
   assign out_err_o    = out_err_q;
   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;

endmodule
